// File: rtl/dig_cor_mc_pkg.sv
// dig_cor_mc_pkg: state encoding, coefficient slots and saturation helpers
// shared by the multi-channel correction core and its datapath.
package dig_cor_mc_pkg;

    typedef enum logic [2:0] {
        INIT_RD,
        INIT_CAP,
        IDLE,
        ERR,
        INTEG,
        DERIV,
        MAC,
        OUT
    } state_t;

    localparam int COEF_XSET = 0;
    localparam int COEF_P    = 1;
    localparam int COEF_I    = 2;
    localparam int COEF_D    = 3;

    // Signed saturation of x into a w-bit two's complement range.
    function automatic longint sat_s(input longint x, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        if (x > hi)
            sat_s = hi;
        else if (x < lo)
            sat_s = lo;
        else
            sat_s = x;
    endfunction

    // Clamp x into the unsigned range 0 .. 2^w-1.
    function automatic longint clamp_u(input longint x, input int w);
        longint hi;
        hi = (longint'(1) <<< w) - 1;
        if (x < 0)
            clamp_u = 0;
        else if (x > hi)
            clamp_u = hi;
        else
            clamp_u = x;
    endfunction

endpackage

// File: rtl/dig_cor_mc_dp.sv
// dig_cor_mc_dp: error/derivative saturation, integrator step, MAC and duty clamp.
// The derivative path exists only when DIG_COR_MC_DTERM_EN is defined.
module dig_cor_mc_dp
    import dig_cor_mc_pkg::*;
#(
    parameter int DW   = 14,
    parameter int GW   = 8,
    parameter int IW   = 18,
    parameter int FRAC = 6
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_acc_en,
    input  logic signed [DW-1:0] i_xset,
    input  logic signed [DW-1:0] i_xmeas,
    input  logic signed [DW-1:0] i_err,
    input  logic signed [IW-1:0] i_sum,
    input  logic signed [GW-1:0] i_kp,
    input  logic signed [GW-1:0] i_ki,
`ifdef DIG_COR_MC_DTERM_EN
    input  logic signed [DW-1:0] i_pre,
    input  logic signed [DW-1:0] i_d,
    input  logic signed [GW-1:0] i_kd,
    output logic signed [DW-1:0] o_d,
`endif
    output logic signed [DW-1:0] o_err,
    output logic signed [IW-1:0] o_sum_nx,
    output logic        [DW-1:0] o_duty
);

    localparam int ACW = IW + GW + 2;

    logic signed [ACW-1:0] r_acc;
    logic signed [ACW-1:0] w_mac;
    logic signed [ACW-1:0] w_shr;

    // Saturated arithmetic feeding the per-state registers in the top.
    always_comb begin
        o_err    = DW'(sat_s(longint'(i_xset) - longint'(i_xmeas), DW));
        o_sum_nx = IW'(sat_s(longint'(i_sum) + longint'(i_err), IW));
`ifdef DIG_COR_MC_DTERM_EN
        o_d      = DW'(sat_s(longint'(i_err) - longint'(i_pre), DW));
        w_mac    = ACW'(i_kp) * ACW'(i_err)
                 + ACW'(i_ki) * ACW'(i_sum)
                 + ACW'(i_kd) * ACW'(i_d);
`else
        w_mac    = ACW'(i_kp) * ACW'(i_err)
                 + ACW'(i_ki) * ACW'(i_sum);
`endif
        w_shr    = r_acc >>> FRAC;
        o_duty   = DW'(clamp_u(longint'(w_shr), DW));
    end

    // Accumulator is wide enough that the three products never overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_acc <= '0;
        else if (i_acc_en)
            r_acc <= w_mac;
    end

endmodule

// File: rtl/dig_cor_mc.sv
// dig_cor_mc: time-multiplexed PID core for NCH channels with EEPROM-loaded
// coefficients. DIG_COR_MC_DTERM_EN enables the derivative term.
module dig_cor_mc
    import dig_cor_mc_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int DW   = 14,
    parameter int GW   = 8,
    parameter int IW   = 18,
    parameter int FRAC = 6
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frm_rdy,
    input  logic [$clog2(NCH):0]     ch_sel,
    input  logic [DW-1:0]            Xmeas,
    input  logic                     accel_vld,
    output logic                     clr_rdy,
    output logic                     eep_cs_n,
    output logic                     eep_r_w_n,
    output logic [$clog2(NCH)+1:0]   eep_addr,
    input  logic [DW-1:0]            eep_rd_data,
    output logic [DW-1:0]            dst,
    output logic [$clog2(NCH)-1:0]   dst_ch,
    output logic                     wrt_duty,
    output logic                     busy
);

    localparam int CW = $clog2(NCH);
    localparam int AW = CW + 2;

    state_t r_state;
    state_t w_nxt;

    logic        [AW-1:0] r_k;
    logic        [CW-1:0] r_ch;
    logic signed [DW-1:0] r_xm;
    logic signed [DW-1:0] r_err;
    logic signed [DW-1:0] r_xset [NCH];
    logic signed [GW-1:0] r_kp   [NCH];
    logic signed [GW-1:0] r_ki   [NCH];
    logic signed [IW-1:0] r_sum  [NCH];
`ifdef DIG_COR_MC_DTERM_EN
    logic signed [GW-1:0] r_kd   [NCH];
    logic signed [DW-1:0] r_pre  [NCH];
    logic signed [DW-1:0] r_d;
    logic signed [DW-1:0] w_d;
`endif

    logic                 r_clr;
    logic                 r_wrt;
    logic        [DW-1:0] r_dst;
    logic        [CW-1:0] r_dst_ch;

    logic signed [DW-1:0] w_err;
    logic signed [IW-1:0] w_sum_nx;
    logic        [DW-1:0] w_duty;
    logic                 w_take;
    logic                 w_ch_ok;

    // The ack pulse blocks a second take of a frame still held by the source.
    assign w_take  = (r_state == IDLE) && frm_rdy && !r_clr;
    assign w_ch_ok = !ch_sel[CW];

    assign clr_rdy   = r_clr;
    assign wrt_duty  = r_wrt;
    assign dst       = r_dst;
    assign dst_ch    = r_dst_ch;
    assign eep_r_w_n = 1'b1;
    assign eep_addr  = r_k;
    assign eep_cs_n  = rst || (r_state != INIT_RD);
    assign busy      = (r_state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= INIT_RD;
        else
            r_state <= w_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            INIT_RD:  w_nxt = INIT_CAP;
            INIT_CAP: w_nxt = (r_k == AW'(4 * NCH - 1)) ? IDLE : INIT_RD;
            IDLE:     w_nxt = (w_take && w_ch_ok) ? ERR : IDLE;
            ERR:      w_nxt = INTEG;
`ifdef DIG_COR_MC_DTERM_EN
            INTEG:    w_nxt = DERIV;
`else
            INTEG:    w_nxt = MAC;
`endif
            DERIV:    w_nxt = MAC;
            MAC:      w_nxt = OUT;
            OUT:      w_nxt = IDLE;
        endcase
    end

    // Coefficient file load: word address = channel*4 + coefficient slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_xset[i] <= '0;
                r_kp[i]   <= '0;
                r_ki[i]   <= '0;
`ifdef DIG_COR_MC_DTERM_EN
                r_kd[i]   <= '0;
`endif
            end
        end else if (r_state == INIT_CAP) begin
            r_k <= r_k + 1'b1;
            unique case (r_k[1:0])
                2'(COEF_XSET): r_xset[r_k[AW-1:2]] <= eep_rd_data;
                2'(COEF_P):    r_kp[r_k[AW-1:2]]   <= eep_rd_data[GW-1:0];
                2'(COEF_I):    r_ki[r_k[AW-1:2]]   <= eep_rd_data[GW-1:0];
                2'(COEF_D): begin
`ifdef DIG_COR_MC_DTERM_EN
                    r_kd[r_k[AW-1:2]] <= eep_rd_data[GW-1:0];
`endif
                end
            endcase
        end
    end

    // Frame capture and per-channel integrator / previous-error state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr <= 1'b0;
            r_ch  <= '0;
            r_xm  <= '0;
            r_err <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_sum[i] <= '0;
`ifdef DIG_COR_MC_DTERM_EN
                r_pre[i] <= '0;
`endif
            end
`ifdef DIG_COR_MC_DTERM_EN
            r_d   <= '0;
`endif
        end else begin
            r_clr <= w_take;
            if (w_take && w_ch_ok) begin
                r_ch <= ch_sel[CW-1:0];
                r_xm <= Xmeas;
            end
            if (r_state == ERR)
                r_err <= w_err;
            if (r_state == INTEG && accel_vld)
                r_sum[r_ch] <= w_sum_nx;
`ifdef DIG_COR_MC_DTERM_EN
            if (r_state == DERIV) begin
                r_d         <= w_d;
                r_pre[r_ch] <= r_err;
            end
`endif
        end
    end

    // Duty word and its channel hold until the next OUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrt    <= 1'b0;
            r_dst    <= '0;
            r_dst_ch <= '0;
        end else begin
            r_wrt <= (r_state == OUT);
            if (r_state == OUT) begin
                r_dst    <= w_duty;
                r_dst_ch <= r_ch;
            end
        end
    end

    dig_cor_mc_dp #(
        .DW   (DW),
        .GW   (GW),
        .IW   (IW),
        .FRAC (FRAC)
    ) u_dp (
        .clk      (clk),
        .rst      (rst),
        .i_acc_en (r_state == MAC),
        .i_xset   (r_xset[r_ch]),
        .i_xmeas  (r_xm),
        .i_err    (r_err),
        .i_sum    (r_sum[r_ch]),
        .i_kp     (r_kp[r_ch]),
        .i_ki     (r_ki[r_ch]),
`ifdef DIG_COR_MC_DTERM_EN
        .i_pre    (r_pre[r_ch]),
        .i_d      (r_d),
        .i_kd     (r_kd[r_ch]),
        .o_d      (w_d),
`endif
        .o_err    (w_err),
        .o_sum_nx (w_sum_nx),
        .o_duty   (w_duty)
    );

endmodule

// File: tb/tb_dig_cor_mc.sv
// tb_dig_cor_mc: scoreboard bench for dig_cor_mc with an arithmetic PID model.
// Expectations follow DIG_COR_MC_DTERM_EN when it is defined for the build.
module tb_dig_cor_mc;

    localparam int NCH = 4;
`ifdef DIG_COR_MC_DTERM_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    typedef struct {
        int dst;
        int ch;
        int cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frm_rdy = 1'b0;
    logic [2:0]  ch_sel = '0;
    logic [13:0] Xmeas = '0;
    logic        accel_vld = 1'b0;
    logic        clr_rdy;
    logic        eep_cs_n;
    logic        eep_r_w_n;
    logic [3:0]  eep_addr;
    logic [13:0] eep_rd_data = '0;
    logic [13:0] dst;
    logic [1:0]  dst_ch;
    logic        wrt_duty;
    logic        busy;

    logic [13:0] mem [4*NCH];
    int          m_sum [NCH];
    int          m_pre [NCH];
    exp_t        sbq [$];
    exp_t        e;
    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    int          nwrt = 0;
    int          last_dst = 0;

    dig_cor_mc u_dut (
        .clk         (clk),
        .rst         (rst),
        .frm_rdy     (frm_rdy),
        .ch_sel      (ch_sel),
        .Xmeas       (Xmeas),
        .accel_vld   (accel_vld),
        .clr_rdy     (clr_rdy),
        .eep_cs_n    (eep_cs_n),
        .eep_r_w_n   (eep_r_w_n),
        .eep_addr    (eep_addr),
        .eep_rd_data (eep_rd_data),
        .dst         (dst),
        .dst_ch      (dst_ch),
        .wrt_duty    (wrt_duty),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // EEPROM: data valid in the cycle after the strobe.
    always @(posedge clk) begin
        if (!eep_cs_n && eep_r_w_n)
            eep_rd_data <= mem[eep_addr];
    end

    task automatic chk(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic int sxt(input logic [13:0] w, input int nb);
        int v;
        v = int'(w) & ((1 << nb) - 1);
        if (v >= (1 << (nb - 1)))
            v -= (1 << nb);
        return v;
    endfunction

    function automatic int sat(input int x, input int nb);
        int hi;
        int lo;
        hi = (1 << (nb - 1)) - 1;
        lo = -(1 << (nb - 1));
        return (x > hi) ? hi : ((x < lo) ? lo : x);
    endfunction

    // Behavioural PID step for one frame; returns the expected duty.
    function automatic int model(input int ch, input int xm, input bit av);
        int xs, kp, ki, kd, err, d, acc, q;
        xs  = sxt(mem[ch*4+0], 14);
        kp  = sxt(mem[ch*4+1], 8);
        ki  = sxt(mem[ch*4+2], 8);
        err = sat(xs - xm, 14);
        if (av)
            m_sum[ch] = sat(m_sum[ch] + err, 18);
`ifdef DIG_COR_MC_DTERM_EN
        kd  = sxt(mem[ch*4+3], 8);
        d   = sat(err - m_pre[ch], 14);
        m_pre[ch] = err;
`else
        kd  = 0;
        d   = 0;
`endif
        acc = kp * err + ki * m_sum[ch] + kd * d;
        q   = acc >>> 6;
        return (q < 0) ? 0 : ((q > 16383) ? 16383 : q);
    endfunction

    // Monitor: every duty pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && wrt_duty) begin
            nwrt++;
            last_dst = int'(dst);
            if (sbq.size() == 0) begin
                chk("spurious_wrt", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("dst", int'(dst), e.dst);
                chk("dst_ch", int'(dst_ch), e.ch);
                chk("wrt_latency", cyc, e.cyc);
            end
        end
    end

    task automatic do_init();
        int bad;
        rst = 1'b1;
        frm_rdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_clr_rdy", clr_rdy, 0);
        chk("rst_wrt_duty", wrt_duty, 0);
        chk("rst_dst", dst, 0);
        chk("rst_dst_ch", dst_ch, 0);
        chk("rst_eep_cs_n", eep_cs_n, 1);
        chk("rst_eep_addr", eep_addr, 0);
        chk("rst_busy", busy, 1);
        sbq.delete();
        for (int i = 0; i < NCH; i++) begin
            m_sum[i] = 0;
            m_pre[i] = 0;
        end
        rst = 1'b0;
        #1;
        bad = 0;
        for (int k = 0; k < 4 * NCH; k++) begin
            if (eep_cs_n !== 1'b0 || eep_addr !== 4'(k) || busy !== 1'b1)
                bad++;
            @(negedge clk);
            if (eep_cs_n !== 1'b1 || busy !== 1'b1)
                bad++;
            @(negedge clk);
        end
        chk("init_seq", bad, 0);
        chk("busy_fall", busy, 0);
    endtask

    task automatic send(input int ch, input int xm, input bit av,
                        input bit nowait, output int ack);
        int n;
        @(negedge clk);
        frm_rdy = 1'b1;
        ch_sel = 3'(ch);
        Xmeas = 14'(xm);
        accel_vld = av;
        n = 0;
        while (!clr_rdy && n < 60) begin
            @(negedge clk);
            n++;
        end
        frm_rdy = 1'b0;
        ack = cyc;
        if (!clr_rdy)
            chk("ack_timeout", 1, 0);
        else if (ch < NCH)
            sbq.push_back('{model(ch, xm, av), ch, cyc + LAT});
        if (!nowait) begin
            n = 0;
            while (sbq.size() != 0 && n < 30) begin
                @(negedge clk);
                n++;
            end
            if (sbq.size() != 0) begin
                chk("wrt_timeout", 1, 0);
                sbq.delete();
            end
        end
    endtask

    task automatic set_ch(input int ch, input int xs, input int p,
                          input int i, input int d);
        mem[ch*4+0] = 14'(xs);
        mem[ch*4+1] = 14'(p);
        mem[ch*4+2] = 14'(i);
        mem[ch*4+3] = 14'(d);
    endtask

    initial begin
        int ack;
        int ack2;
        int n0;
        int ch;

        for (int k = 0; k < 4 * NCH; k++)
            mem[k] = 14'(100 + k);
        do_init();
        send(1, $urandom_range(0, 16383) - 8192, 1'b1, 1'b0, ack);
        send(2, $urandom_range(0, 16383) - 8192, 1'b1, 1'b0, ack);

        set_ch(0, 0, 0, 0, 64);
        set_ch(1, 1000, 64, 0, 0);
        set_ch(2, 100, 0, 1, 0);
        set_ch(3, 8191, 0, 127, 0);
        do_init();

        send(1, 900, 1'b1, 1'b0, ack);
        chk("p_only", last_dst, 100);
        send(1, 1100, 1'b1, 1'b0, ack);
        chk("clamp_low", last_dst, 0);

        send(2, 0, 1'b1, 1'b0, ack);
        chk("integ_1", last_dst, 1);
        send(2, 0, 1'b1, 1'b0, ack);
        chk("integ_2", last_dst, 3);
        send(2, 0, 1'b1, 1'b0, ack);
        chk("integ_3", last_dst, 4);
        send(2, 0, 1'b0, 1'b0, ack);
        chk("integ_hold", last_dst, 4);

        for (int k = 0; k < 20; k++)
            send(3, -8192, 1'b1, 1'b0, ack);
        chk("clamp_high", last_dst, 16383);

        send(0, -10, 1'b1, 1'b0, ack);
`ifdef DIG_COR_MC_DTERM_EN
        chk("dterm_1", last_dst, 10);
`else
        chk("dterm_1", last_dst, 0);
`endif
        send(0, -10, 1'b1, 1'b0, ack);
        chk("dterm_2", last_dst, 0);

        n0 = nwrt;
        send(4, 123, 1'b1, 1'b0, ack);
        repeat (10) @(negedge clk);
        chk("drop_no_wrt", nwrt - n0, 0);

        send(1, 900, 1'b1, 1'b1, ack);
        send(1, 1100, 1'b1, 1'b0, ack2);
        chk("busy_hold", (ack2 - ack) >= LAT + 1, 1);

        send(1, 900, 1'b1, 1'b1, ack);
        while (cyc < ack + 3)
            @(negedge clk);
        n0 = nwrt;
        do_init();
        chk("abort_no_wrt", nwrt - n0, 0);

        for (int ep = 0; ep < 3; ep++) begin
            for (int k = 0; k < 4 * NCH; k++)
                mem[k] = 14'($urandom_range(0, 16383));
            do_init();
            for (int f = 0; f < 25; f++) begin
                ch = $urandom_range(0, 5);
                if (ch >= NCH)
                    ch = NCH + $urandom_range(0, 3);
                send(ch, $urandom_range(0, 16383) - 8192,
                     ($urandom_range(0, 3) != 0), 1'b0, ack);
            end
        end

        repeat (5) @(negedge clk);
        chk("queue_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
